// File: rtl/gba_eeprom_bridge_if.sv
// Cartridge-bus side of the EEPROM bridge: one strobe per halfword access.
// req is a single-cycle strobe; ack is a one-cycle pulse closing an accepted window hit.
interface gba_eeprom_bridge_if #(
    parameter int ADDR_W = 28
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [15:0]       rdata;
    logic              ack;
    logic              hit;

    modport master (output req, we, addr, wdata, input rdata, ack, hit);
    modport slave  (input req, we, addr, wdata, output rdata, ack, hit);
endinterface

// File: rtl/gba_eeprom_bridge.sv
// Converts GBA EEPROM-window halfword accesses into single-bit serial core transactions,
// infers the EEPROM size from write burst lengths and requests a save after a quiet period.
module gba_eeprom_bridge #(
    parameter logic [23:0] FLUSH_IDLE = 24'd8_388_608,
    parameter int          ADDR_W     = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rom_32m,
    input  logic                model_default,
    gba_eeprom_bridge_if.slave  bus,
    output logic                ee_cs,
    output logic                ee_valid,
    output logic                ee_write,
    output logic                ee_din,
    input  logic                ee_ready,
    input  logic                ee_dout,
    output logic                model,
    output logic                dirty,
    output logic                flush_req,
    input  logic                dirty_clr,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_ACK} state_t;

    state_t      state, state_nxt;
    logic        we_q, bit_q;
    logic        ack_q, rdata_bit;
    logic [6:0]  burst_len;
    logic [23:0] idle_cnt, idle_inc;
    logic        in_window, accept, wr_acc, rd_acc;
    logic        cls_hit, cls_model, cls_dirty;
    logic        unused_bits;

    // Large ROMs leave only the top 256 bytes of the 0xD region to the EEPROM.
    assign in_window   = (bus.addr[ADDR_W-1 -: 4] == 4'hD) &&
                         (!rom_32m || (&bus.addr[ADDR_W-5:8]));
    assign bus.hit     = bus.req && in_window;
    assign bus.ack     = ack_q;
    assign bus.rdata   = {15'b0, rdata_bit};
    assign state_dbg   = state;
    assign unused_bits = ^{bus.wdata[15:1], bus.addr[7:0]};

    assign accept   = (state == S_ISSUE) && ee_ready;
    assign wr_acc   = accept && we_q;
    assign rd_acc   = accept && !we_q;
    assign idle_inc = idle_cnt + 24'd1;

    always_comb begin
        state_nxt = state;
        ee_cs     = 1'b0;
        ee_valid  = 1'b0;
        ee_write  = 1'b0;
        ee_din    = 1'b0;
        case (state)
            S_IDLE:   if (bus.hit) state_nxt = S_ISSUE;
            S_ISSUE: begin
                ee_cs    = 1'b1;
                ee_valid = 1'b1;
                ee_write = we_q;
                ee_din   = bit_q;
                if (ee_ready) state_nxt = we_q ? S_ACK : S_RDWAIT;
            end
            S_RDWAIT: state_nxt = S_ACK;
            S_ACK:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Burst lengths: 9/17 are read-address commands, 73/81 are full write commands.
    always_comb begin
        cls_hit   = 1'b0;
        cls_model = 1'b0;
        cls_dirty = 1'b0;
        case (burst_len)
            7'd9:    begin cls_hit = 1'b1; cls_model = 1'b0; end
            7'd17:   begin cls_hit = 1'b1; cls_model = 1'b1; end
            7'd73:   begin cls_hit = 1'b1; cls_model = 1'b0; cls_dirty = 1'b1; end
            7'd81:   begin cls_hit = 1'b1; cls_model = 1'b1; cls_dirty = 1'b1; end
            default: cls_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            bit_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_bit <= 1'b0;
            model     <= model_default;
            dirty     <= 1'b0;
            flush_req <= 1'b0;
            burst_len <= 7'd0;
            idle_cnt  <= 24'd0;
        end else begin
            state <= state_nxt;
            ack_q <= (state == S_ACK);
            if (state == S_IDLE && bus.hit) begin
                we_q  <= bus.we;
                bit_q <= bus.wdata[0];
            end
            if (state == S_RDWAIT) rdata_bit <= ee_dout;

            if (wr_acc && burst_len != 7'd127) burst_len <= burst_len + 7'd1;
            else if (rd_acc)                   burst_len <= 7'd0;

            if (rd_acc && cls_hit) model <= cls_model;

            // A new completed write outranks a simultaneous save acknowledgement.
            if (rd_acc && cls_dirty) dirty <= 1'b1;
            else if (dirty_clr)      dirty <= 1'b0;

            if (bus.hit)                             idle_cnt <= 24'd0;
            else if (dirty && idle_cnt != 24'hFFFFFF) idle_cnt <= idle_inc;

            flush_req <= !bus.hit && dirty && (idle_cnt != 24'hFFFFFF) &&
                         (idle_inc == FLUSH_IDLE - 24'd1);
        end
    end
endmodule

// File: tb/tb_gba_eeprom_bridge.sv
// Directed bench for gba_eeprom_bridge: serial-core conversion, window decode, size inference,
// dirty tracking and flush timing, with an expected-read-data queue checked at each ack.
module tb_gba_eeprom_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rom_32m = 1'b0;
    logic model_default = 1'b0;
    logic ee_cs, ee_valid, ee_write, ee_din;
    logic ee_ready = 1'b1;
    logic ee_dout = 1'b0;
    logic model, dirty, flush_req;
    logic dirty_clr = 1'b0;
    logic [1:0] state_dbg;

    gba_eeprom_bridge_if #(.ADDR_W(28)) bif ();

    gba_eeprom_bridge #(.FLUSH_IDLE(24'd16), .ADDR_W(28)) dut (
        .clk(clk), .rst_n(rst_n), .rom_32m(rom_32m), .model_default(model_default),
        .bus(bif.slave),
        .ee_cs(ee_cs), .ee_valid(ee_valid), .ee_write(ee_write), .ee_din(ee_din),
        .ee_ready(ee_ready), .ee_dout(ee_dout),
        .model(model), .dirty(dirty), .flush_req(flush_req), .dirty_clr(dirty_clr),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_hit = 0;
    logic [15:0] exp_q[$];
    int flush_at[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (flush_req) flush_at.push_back(cyc);

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus access; exp_lat < 0 means the access must be ignored.
    task automatic access(input bit w, input logic [27:0] a, input bit b, input int stall,
                          input int exp_lat, input bit clr_acc);
        int lat, vcyc, lim;
        bit sig_ok, hit0;
        logic [14:0] rnd;
        logic [15:0] exp_rd;
        lat = -1; vcyc = 0; sig_ok = 1'b1; hit0 = 1'b0;
        lim = (exp_lat < 0) ? 8 : exp_lat + 4;
        rnd = 15'($urandom_range(0, 32767));
        @(posedge clk); #1;
        bif.req = 1'b1; bif.we = w; bif.addr = a; bif.wdata = {rnd, b};
        ee_dout = b; ee_ready = (stall == 0);
        if (exp_lat >= 0 && !w) exp_q.push_back({15'b0, b});
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            if (c == 0) begin
                hit0 = bif.hit;
                if (bif.hit) last_hit = cyc;
            end
            if (ee_valid) begin
                vcyc++;
                if (ee_write !== w || ee_din !== b || ee_cs !== 1'b1) sig_ok = 1'b0;
            end
            if (bif.ack) begin
                lat = c;
                if (!w) begin
                    if (exp_q.size() == 0) check("rdata_unexpected", 1, 0);
                    else begin
                        exp_rd = exp_q.pop_front();
                        check("rdata", bif.rdata, exp_rd);
                    end
                end
            end
            @(posedge clk); #1;
            bif.req = 1'b0;
            ee_ready = (c + 1 > stall);
            dirty_clr = clr_acc && (c == 0);
            if (lat >= 0) break;
        end
        dirty_clr = 1'b0;
        ee_ready = 1'b1;
        check("hit", hit0, (exp_lat >= 0));
        check("latency", lat, exp_lat);
        check("valid_cycles", vcyc, (exp_lat >= 0) ? stall + 1 : 0);
        check("ee_signals", sig_ok, 1);
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++)
            access(1'b1, 28'hD000000 | 28'($urandom_range(0, 24'hFFFFFF)),
                   1'($urandom_range(0, 1)), 0, 3, 1'b0);
    endtask

    task automatic rd(input bit b, input bit clr_acc);
        access(1'b0, 28'hDFFFF00 | 28'($urandom_range(0, 255)), b, 0, 4, clr_acc);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; dirty_clr = 1'b1;
        @(posedge clk); #1; dirty_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int acks;
        bif.req = 1'b0; bif.we = 1'b0; bif.addr = '0; bif.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", bif.ack, 0);
        check("rst_rdata", bif.rdata, 16'h0000);
        check("rst_ee", {ee_cs, ee_valid, ee_write, ee_din}, 4'b0000);
        check("rst_model", model, 0);
        check("rst_dirty", dirty, 0);
        check("rst_flush", flush_req, 0);
        check("rst_state", state_dbg, 0);
        #1 rst_n = 1'b1;

        // basic write and reads
        access(1'b1, 28'hD000000, 1'b1, 0, 3, 1'b0);
        rd(1'b1, 1'b0);
        rd(1'b0, 1'b0);
        check("model_after_poll", model, 0);

        // window decode
        access(1'b1, 28'hC000000, 1'b1, 0, -1, 1'b0);
        access(1'b0, 28'hDFFFFFF, 1'b1, 0, 4, 1'b0);
        rom_32m = 1'b1;
        access(1'b1, 28'hD000000, 1'b1, 0, -1, 1'b0);
        access(1'b0, 28'hDFFFEFF, 1'b0, 0, -1, 1'b0);
        access(1'b0, 28'hDFFFF00, 1'b1, 0, 4, 1'b0);
        access(1'b1, 28'hDFFFFFF, 1'b0, 0, 3, 1'b0);
        rd(1'b0, 1'b0);
        check("rdata_hold", bif.rdata, 16'h0000);
        rom_32m = 1'b0;

        // size inference
        burst(17); rd(1'b1, 1'b0);
        check("model_17", model, 1);
        check("dirty_17", dirty, 0);
        burst(73); rd(1'b0, 1'b0);
        check("model_73", model, 0);
        check("dirty_73", dirty, 1);

        pulse_clr();
        check("dirty_clr", dirty, 0);
        pulse_clr();
        check("dirty_clr_idle", dirty, 0);
        burst(73); rd(1'b1, 1'b1);
        check("dirty_set_wins", dirty, 1);
        pulse_clr();
        check("dirty_clr2", dirty, 0);

        // flush after quiet period
        burst(81); rd(1'b0, 1'b0);
        check("model_81", model, 1);
        check("dirty_81", dirty, 1);
        rd(1'b1, 1'b0); rd(1'b0, 1'b0);
        check("model_poll", model, 1);
        flush_at.delete();
        repeat (40) @(negedge clk);
        check("flush_count", flush_at.size(), 1);
        if (flush_at.size() > 0) check("flush_delay", flush_at[0] - last_hit, 16);
        check("dirty_before_clr", dirty, 1);
        pulse_clr();
        check("dirty_after_flush_clr", dirty, 0);

        // ready stall
        access(1'b1, 28'hD000010, 1'b1, 5, 8, 1'b0);
        access(1'b0, 28'hD000010, 1'b1, 5, 9, 1'b0);

        // reset mid-ISSUE
        @(posedge clk); #1;
        bif.req = 1'b1; bif.we = 1'b1; bif.addr = 28'hD000000; bif.wdata = 16'h0001; ee_ready = 1'b0;
        @(posedge clk); #1; bif.req = 1'b0;
        @(negedge clk);
        check("stall_valid", ee_valid, 1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; ee_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", ee_valid, 0);
        check("rst_mid_state", state_dbg, 0);
        check("rst_mid_model", model, 0);
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (bif.ack) acks++;
        end
        check("rst_mid_noack", acks, 0);

        // burst length saturation
        burst(17); rd(1'b0, 1'b0);
        check("model_17b", model, 1);
        burst(137); rd(1'b1, 1'b0);
        check("sat_137_model", model, 1);
        check("sat_137_dirty", dirty, 0);
        burst(200); rd(1'b0, 1'b0);
        check("sat_200_model", model, 1);
        check("sat_200_dirty", dirty, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
